// File: rtl/layer_priority_ctrl.sv
// layer_priority_ctrl: per-pixel layer priority mux with a double-buffered priority table.
// Define LAYER_PRIORITY_FLASH_EN to build the hit-flash sequencer (inverts winner on alternate frames).
module layer_priority_ctrl #(
  parameter int NUM_LAYERS   = 6,
  parameter int IDX_W        = 3,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   layerDrawingRequest,
  input  logic [8*NUM_LAYERS-1:0] layerRGB,
  input  logic [7:0]              backGroundRGB,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [IDX_W-1:0]        cfg_slot,
  input  logic [IDX_W-1:0]        cfg_layer,
  input  logic                    cfg_commit,
  input  logic                    flash_trigger,
  output logic [7:0]              pixelRGB,
  output logic [IDX_W-1:0]        selLayer,
  output logic                    flash_active
);

  localparam logic [IDX_W-1:0] NL = IDX_W'(NUM_LAYERS);

  logic [IDX_W-1:0] active_tbl [NUM_LAYERS];
  logic [IDX_W-1:0] shadow_tbl [NUM_LAYERS];
  logic             pending;
  logic [7:0]       rgb_arr [NUM_LAYERS];
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [7:0]       win_rgb;
  logic             invert_pixel;

  assign cfg_ready = ~pending;

  always_comb begin
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      rgb_arr[IDX_W'(i)] = layerRGB[8*i +: 8];
    end
  end

  // First slot holding a valid, requesting layer wins; duplicates resolve to the earliest slot.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '1;
    win_rgb   = backGroundRGB;
    for (int unsigned s = 0; s < NUM_LAYERS; s++) begin
      if (!win_found && (active_tbl[IDX_W'(s)] < NL)) begin
        if (layerDrawingRequest[active_tbl[IDX_W'(s)]]) begin
          win_found = 1'b1;
          win_idx   = active_tbl[IDX_W'(s)];
          win_rgb   = rgb_arr[active_tbl[IDX_W'(s)]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixelRGB <= '0;
      selLayer <= '1;
    end else begin
      selLayer <= win_idx;
      pixelRGB <= (win_found && invert_pixel) ? ~win_rgb : win_rgb;
    end
  end

  // Shadow writes are frozen while a commit waits for the next frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        active_tbl[IDX_W'(i)] <= IDX_W'(i);
        shadow_tbl[IDX_W'(i)] <= IDX_W'(i);
      end
    end else if (pending) begin
      if (startOfFrame) begin
        active_tbl <= shadow_tbl;
        pending    <= 1'b0;
      end
    end else begin
      if (cfg_valid && (cfg_slot < NL)) begin
        shadow_tbl[cfg_slot] <= cfg_layer;
      end
      if (cfg_commit) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef LAYER_PRIORITY_FLASH_EN
  typedef enum logic [1:0] {
    FL_IDLE,
    FL_ARMED,
    FL_RUN
  } flash_state_t;

  localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

  flash_state_t flash_state;
  logic [7:0]   frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_state  <= FL_IDLE;
      frame_cnt    <= '0;
      flash_active <= 1'b0;
    end else begin
      case (flash_state)
        FL_IDLE: begin
          if (flash_trigger) begin
            flash_state  <= FL_ARMED;
            flash_active <= 1'b1;
          end
        end
        FL_ARMED: begin
          if (startOfFrame) begin
            flash_state <= FL_RUN;
            frame_cnt   <= '0;
          end
        end
        FL_RUN: begin
          if (startOfFrame) begin
            if (frame_cnt == LAST_FRAME) begin
              flash_state  <= FL_IDLE;
              flash_active <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          flash_state  <= FL_IDLE;
          flash_active <= 1'b0;
        end
      endcase
    end
  end

  // The SOF pixel belongs to the frame being entered, so look ahead on startOfFrame.
  always_comb begin
    invert_pixel = 1'b0;
    case (flash_state)
      FL_ARMED: invert_pixel = startOfFrame;
      FL_RUN:   invert_pixel = startOfFrame ? ((frame_cnt != LAST_FRAME) && frame_cnt[0])
                                            : !frame_cnt[0];
      default:  invert_pixel = 1'b0;
    endcase
  end
`else
  logic unused_flash_trigger;
  assign unused_flash_trigger = flash_trigger;
  assign flash_active         = 1'b0;
  assign invert_pixel         = 1'b0;
`endif

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Randomized bench for layer_priority_ctrl with a frame-level reference model and pinned directed cases.
module tb_layer_priority_ctrl;

  localparam int NL = 6;
  localparam int FF = 4;
`ifdef LAYER_PRIORITY_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          startOfFrame;
  logic [NL-1:0] layerDrawingRequest;
  logic [8*NL-1:0] layerRGB;
  logic [7:0]    backGroundRGB;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_slot;
  logic [2:0]    cfg_layer;
  logic          cfg_commit;
  logic          flash_trigger;
  logic [7:0]    pixelRGB;
  logic [2:0]    selLayer;
  logic          flash_active;

  layer_priority_ctrl #(.NUM_LAYERS(NL), .IDX_W(3), .FLASH_FRAMES(FF)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .layerDrawingRequest(layerDrawingRequest), .layerRGB(layerRGB),
    .backGroundRGB(backGroundRGB), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_slot(cfg_slot), .cfg_layer(cfg_layer), .cfg_commit(cfg_commit),
    .flash_trigger(flash_trigger), .pixelRGB(pixelRGB), .selLayer(selLayer),
    .flash_active(flash_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: priority tables as int arrays, flash as an armed flag plus frame number.
  int m_act[NL];
  int m_shd[NL];
  bit m_pend, m_armed, m_valid = 1'b0;
  int m_frame;
  int e_pix, e_sel;
  bit e_ready, e_flash;

  task automatic model_step();
    int w, pf;
    bit inv;
    if (reset) begin
      for (int i = 0; i < NL; i++) begin
        m_act[i] = i;
        m_shd[i] = i;
      end
      m_pend = 0; m_armed = 0; m_frame = -1;
      e_pix = 0; e_sel = 7; e_ready = 1; e_flash = 0; m_valid = 1;
      return;
    end
    if (!m_valid) return;
    w = -1;
    for (int s = 0; s < NL; s++)
      if (w < 0 && m_act[s] < NL)
        if (layerDrawingRequest[m_act[s]]) w = m_act[s];
    if (startOfFrame && m_armed) pf = 0;
    else if (m_frame < 0) pf = -1;
    else pf = startOfFrame ? m_frame + 1 : m_frame;
    inv = FLASH_ON && pf >= 0 && pf < FF && (pf % 2 == 0);
    if (w < 0) begin
      e_pix = backGroundRGB;
      e_sel = 7;
    end else begin
      e_pix = layerRGB[8*w +: 8];
      if (inv) e_pix = e_pix ^ 8'hFF;
      e_sel = w;
    end
    if (!m_pend) begin
      if (cfg_valid && cfg_slot < NL) m_shd[cfg_slot] = cfg_layer;
      if (cfg_commit) m_pend = 1;
    end else if (startOfFrame) begin
      m_act = m_shd;
      m_pend = 0;
    end
    if (FLASH_ON) begin
      if (m_armed) begin
        if (startOfFrame) begin m_armed = 0; m_frame = 0; end
      end else if (m_frame >= 0) begin
        if (startOfFrame) begin
          m_frame++;
          if (m_frame == FF) m_frame = -1;
        end
      end else if (flash_trigger) begin
        m_armed = 1;
      end
    end
    e_ready = !m_pend;
    e_flash = m_armed || (m_frame >= 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_pixelRGB", pixelRGB, e_pix);
      chk("model_selLayer", selLayer, e_sel);
      chk("model_cfg_ready", cfg_ready, e_ready);
      chk("model_flash_active", flash_active, e_flash);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int slot, input int layer);
    cfg_valid = 1'b1;
    cfg_slot  = 3'(slot);
    cfg_layer = 3'(layer);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    startOfFrame = 1'b0;
    layerDrawingRequest = 6'b001001;
    layerRGB = {8'h55, 8'h44, 8'h1C, 8'h22, 8'h11, 8'hE0};
    backGroundRGB = 8'h03;
    cfg_valid = 1'b0; cfg_slot = '0; cfg_layer = '0; cfg_commit = 1'b0;
    flash_trigger = 1'b0;
    repeat (3) tick();
    chk("reset_pixel", pixelRGB, 8'h00);
    chk("reset_sel", selLayer, 7);
    chk("reset_ready", cfg_ready, 1);
    chk("reset_flash", flash_active, 0);
    reset = 1'b0;

    tick();
    chk("default_pixel", pixelRGB, 8'hE0);
    chk("default_sel", selLayer, 0);
    layerDrawingRequest = '0;
    tick();
    chk("bg_pixel", pixelRGB, 8'h03);
    chk("bg_sel", selLayer, 7);

    // Reorder slot0 -> layer3, swapped at the next frame
    layerDrawingRequest = 6'b001001;
    cfg_valid = 1'b1; cfg_slot = 3'd0; cfg_layer = 3'd3; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    chk("reorder_pre_pixel", pixelRGB, 8'hE0);
    chk("reorder_ready_low", cfg_ready, 0);
    tick();
    chk("reorder_hold_pixel", pixelRGB, 8'hE0);
    sof();
    chk("reorder_sof_pixel", pixelRGB, 8'hE0);
    chk("reorder_ready_back", cfg_ready, 1);
    tick();
    chk("reorder_new_pixel", pixelRGB, 8'h1C);
    chk("reorder_new_sel", selLayer, 3);

    // Commit coincident with SOF waits for the following SOF
    layerDrawingRequest = 6'b000011;
    cfg_valid = 1'b1; cfg_slot = 3'd1; cfg_layer = 3'd0; cfg_commit = 1'b1;
    startOfFrame = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0; startOfFrame = 1'b0;
    tick();
    chk("sofcommit_old_pixel", pixelRGB, 8'h11);
    chk("sofcommit_pending", cfg_ready, 0);
    sof();
    chk("sofcommit_sof_pixel", pixelRGB, 8'h11);
    tick();
    chk("sofcommit_new_pixel", pixelRGB, 8'hE0);

    // Write while pending is dropped
    commit();
    wr(0, 5);
    sof();
    layerDrawingRequest = 6'b100001;
    tick();
    tick();
    chk("pending_drop_sel", selLayer, 0);

    // Out-of-range slot write is discarded
    wr(6, 5);
    commit();
    sof();
    tick();
    chk("slot6_sel", selLayer, 0);

    // Empty and duplicate slots
    wr(0, 7); wr(1, 7); wr(2, 2); wr(3, 2); wr(4, 0); wr(5, 1);
    commit();
    sof();
    layerDrawingRequest = 6'b000101;
    tick();
    tick();
    chk("dup_pixel", pixelRGB, 8'h22);
    chk("dup_sel", selLayer, 2);
    layerDrawingRequest = 6'b111000;
    tick();
    tick();
    chk("absent_pixel", pixelRGB, 8'h03);
    chk("absent_sel", selLayer, 7);

    // Flash sequence: winner is layer0 (0xE0) via slot4
    layerDrawingRequest = 6'b000001;
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    chk("flash_armed", flash_active, FLASH_ON);
    sof();
    chk("flash_f0_sof", pixelRGB, FLASH_ON ? 8'h1F : 8'hE0);
    tick();
    chk("flash_f0", pixelRGB, FLASH_ON ? 8'h1F : 8'hE0);
    layerDrawingRequest = '0;
    tick();
    chk("flash_bg", pixelRGB, 8'h03);
    layerDrawingRequest = 6'b000001;
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    chk("flash_retrigger", pixelRGB, FLASH_ON ? 8'h1F : 8'hE0);
    sof();
    chk("flash_f1", pixelRGB, 8'hE0);
    sof();
    chk("flash_f2", pixelRGB, FLASH_ON ? 8'h1F : 8'hE0);
    tick();
    chk("flash_f2b", pixelRGB, FLASH_ON ? 8'h1F : 8'hE0);
    sof();
    chk("flash_f3", pixelRGB, 8'hE0);
    chk("flash_f3_active", flash_active, FLASH_ON);
    sof();
    chk("flash_exit_active", flash_active, 0);
    tick();
    chk("flash_exit_pixel", pixelRGB, 8'hE0);

    // Reset during RUN with a pending commit
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    sof();
    cfg_valid = 1'b1; cfg_slot = 3'd0; cfg_layer = 3'd3; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    chk("midreset_pending", cfg_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_flash", flash_active, 0);
    chk("midreset_ready", cfg_ready, 1);
    chk("midreset_pixel", pixelRGB, 0);
    layerDrawingRequest = 6'b001001;
    tick();
    chk("midreset_identity", pixelRGB, 8'hE0);
    chk("midreset_identity_sel", selLayer, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      layerDrawingRequest = 6'($urandom);
      layerRGB = {$urandom, $urandom};
      backGroundRGB = 8'($urandom);
      startOfFrame = (n % 16 == 0) || ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_slot = 3'($urandom);
      cfg_layer = 3'($urandom);
      cfg_commit = ($urandom_range(0, 9) == 0);
      flash_trigger = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
